mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencing controller around one config_multiplier_4bit instance, which it instantiates internally.
- Accepts signed operand pairs over a valid/ready handshake in three modes:
  - one signed 8x8 multiply, time-multiplexed over four 4x4 partial products;
  - one signed 4x4 multiply;
  - two packed signed 2x2 multiplies.
- Drives the multiplier's precision and Baugh-Wooley invert controls per step, accumulates, and returns a 16-bit result over a valid/ready handshake.

Parameters:
- EN_8BIT, 1: when 0, mode 8b is illegal and is treated like mode 3.
- BW_CORR, 16'h8100: Baugh-Wooley correction constant, added once per 8b operation.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operand request.
- in_ready_o  out  1  controller can accept.
- mode_i  in  2  0 = 8b, 1 = 4b, 2 = 2x2b, 3 = illegal.
- a_i  in  8  multiplier.
  - 4b mode uses [3:0].
  - 2x2b mode: lane0 = [1:0], lane1 = [3:2].
- b_i  in  8  multiplicand, same packing as a_i.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  16  8b: signed 16-bit product. 4b: sign-extended 8-bit product. 2x2b: {8'b0, lane1[3:0], lane0[3:0]}.
- err_o  out  1  qualifies result_o; high for an illegal mode.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state = IDLE, step = 0, accumulator = 0.
  - in_ready_o = 1, out_valid_o = 0, result_o = 0, err_o = 0, busy_o = 0.
  - Reset mid-operation aborts the operation; nothing is emitted.
- FSM states: IDLE, RUN, DONE.
  - in_ready_o = 1 only in IDLE.
  - Accept occurs when in_valid_i && in_ready_o.
  - On accept, latch a_i, b_i and mode_i; clear step and accumulator.
- Transitions:
  - IDLE -> RUN on accept with a legal mode.
  - IDLE -> DONE directly on accept with an illegal mode: result 0, err_o = 1.
  - RUN lasts 4 cycles in 8b mode and 1 cycle in 4b or 2x2b mode, then -> DONE.
  - DONE holds out_valid_o = 1 with result_o and err_o stable until out_ready_i.
  - DONE -> IDLE on the cycle out_ready_i = 1.
  - A new request is accepted no earlier than the following cycle (one bubble).
- Latency, accept edge to out_valid_o rising:
  - 2 cycles in 4b and 2x2b modes.
  - 5 cycles in 8b mode.
  - 1 cycle for an illegal mode.
- 8b step schedule, each RUN cycle (continueHigher = 1, halvedPrecision = 0):
  - step0: a[3:0] x b[3:0]; invertFirstBit = 0, invertSecondRow = 0; shift 0.
  - step1: a[7:4] x b[3:0]; invertFirstBit = 0, invertSecondRow = 1; shift 4.
  - step2: a[3:0] x b[7:4]; invertFirstBit = 1, invertSecondRow = 0; shift 4.
  - step3: a[7:4] x b[7:4]; invertFirstBit = 1, invertSecondRow = 1; shift 8.
  - Accumulate each zero-extended 8-bit step product << shift into the 16-bit accumulator, modulo 2^16.
  - BW_CORR is added at step0.
  - Final value must equal the exact signed product a*b.
- 4b mode: continueHigher = 0, halvedPrecision = 0, both inverts = 1; result_o = sign-extended product[7:0].
- 2x2b mode: halvedPrecision = 1, continueHigher = 0; lanes are independent, no carry between lanes.
- Multiplier inputs are driven from latched operands only; changes on a_i and b_i after accept have no effect.
- in_valid_i while busy: request stalls and is not lost; the requester must hold it.

Test Plan:
- Reset released, mode 0, a = 8'sh80 (-128), b = 8'sh80 -> out_valid_o 5 cycles after accept, result_o = 16'h4000, err_o = 0.
- Mode 0, a = -3 (8'hFD), b = 7 -> result_o = 16'hFFEB (-21); then exhaustive 65536-pair sweep must match the signed product.
- Mode 1, a = 4'h8 (-8), b = 4'h7 -> 2-cycle latency, result_o = 16'hFFC8 (-56); mode 2, a = 4'b1001, b = 4'b1110 -> lane1 = (-2)(-1) = 2, lane0 = (1)(-2) = -2, result_o = 16'h002E.
- Backpressure: hold out_ready_i = 0 for 10 cycles after out_valid_o -> result_o stable, in_ready_o = 0, new in_valid_i ignored; release -> IDLE next cycle, then the pending request is accepted.
- Mode 3 (or mode 0 with EN_8BIT = 0) -> out_valid_o 1 cycle after accept, result_o = 0, err_o = 1.
- Assert rst_ni low during RUN step 2 -> all outputs return to reset values immediately; after release, no stale out_valid_o and the next 8b operation is correct.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller around a configurable 4x4 Baugh-Wooley multiplier.
// Supports one signed 8x8 multiply (four 4x4 partial products accumulated
// over four cycles), one signed 4x4 multiply, or two packed signed 2x2
// multiplies, with valid/ready handshakes on both the request and result sides.

// Configurable 4x4 multiplier.
//   Full precision: signed/unsigned 4x4 product. invert_second_row_i marks
//   a[3] as a negative-weight bit, and invert_first_bit_i marks b[3] as a
//   negative-weight bit.
//   Halved precision: two independent 2x2 lanes, each on bits [1:0] and [3:2].
//   continue_higher_i = 1 leaves the Baugh-Wooley constant out, because the
//   caller folds it into a wider accumulation.
module config_multiplier_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       halved_precision_i,
    input  logic       continue_higher_i,
    input  logic       invert_first_bit_i,
    input  logic       invert_second_row_i,
    output logic [7:0] product_o
);

    logic [7:0]      full_sum;
    logic [7:0]      full_corr;
    logic [1:0][3:0] lane_sum;
    logic [1:0][3:0] lane_corr;

    // Partial-product array: each negative-weight bit is inverted and the
    // matching constant is subtracted (unless the caller takes care of it).
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        full_sum  = '0;
        full_corr = '0;
        lane_sum  = '0;
        lane_corr = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic inv;
                inv = (invert_second_row_i && (i == 3)) ^ (invert_first_bit_i && (j == 3));
                if ((a_i[i] & b_i[j]) ^ inv) full_sum = full_sum + (8'd1 << (i + j));
                if (inv)                     full_corr = full_corr + (8'd1 << (i + j));
            end
        end
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    logic inv;
                    inv = (invert_second_row_i && (i == 1)) ^ (invert_first_bit_i && (j == 1));
                    if ((a_i[2*l+i] & b_i[2*l+j]) ^ inv) lane_sum[l] = lane_sum[l] + (4'd1 << (i + j));
                    if (inv)                             lane_corr[l] = lane_corr[l] + (4'd1 << (i + j));
                end
            end
        end
        if (halved_precision_i) begin
            product_o = continue_higher_i ? {lane_sum[1], lane_sum[0]}
                                          : {lane_sum[1] - lane_corr[1], lane_sum[0] - lane_corr[0]};
        end else begin
            product_o = continue_higher_i ? full_sum : full_sum - full_corr;
        end
    end

endmodule

module mult_seq_ctrl #(
    parameter bit          EN_8BIT = 1'b1,
    parameter logic [15:0] BW_CORR = 16'h8100
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  mode_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] MODE_8B  = 2'd0;
    localparam logic [1:0] MODE_4B  = 2'd1;
    localparam logic [1:0] MODE_2X2 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [1:0]  mode_q, mode_d;
    logic        err_q, err_d;

    logic        in_illegal;
    logic        is_8b;
    logic [3:0]  mul_a, mul_b;
    logic        mul_inv_first, mul_inv_row;
    logic [7:0]  mul_p;
    logic [3:0]  shamt;
    logic [15:0] step_term;

    assign in_illegal = (mode_i == 2'd3) || ((mode_i == MODE_8B) && !EN_8BIT);
    assign is_8b      = (mode_q == MODE_8B);

    // Operand and control selection for the current step, from latched operands only.
    always_comb begin
        mul_a         = (is_8b && step_q[0]) ? a_q[7:4] : a_q[3:0];
        mul_b         = (is_8b && step_q[1]) ? b_q[7:4] : b_q[3:0];
        mul_inv_row   = is_8b ? step_q[0] : 1'b1;
        mul_inv_first = is_8b ? step_q[1] : 1'b1;
        case (step_q)
            2'd0:    shamt = 4'd0;
            2'd3:    shamt = 4'd8;
            default: shamt = 4'd4;
        endcase
        step_term = {8'b0, mul_p} << shamt;
    end

    config_multiplier_4bit u_mul (
        .a_i                 (mul_a),
        .b_i                 (mul_b),
        .halved_precision_i  (mode_q == MODE_2X2),
        .continue_higher_i   (is_8b),
        .invert_first_bit_i  (mul_inv_first),
        .invert_second_row_i (mul_inv_row),
        .product_o           (mul_p)
    );

    // Next-state logic: accept, step/accumulate, and hold the result until taken.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = mode_i;
                    step_d  = 2'd0;
                    acc_d   = '0;
                    err_d   = in_illegal;
                    state_d = in_illegal ? DONE : RUN;
                end
            end
            RUN: begin
                if (is_8b) begin
                    acc_d  = acc_q + step_term + ((step_q == 2'd0) ? BW_CORR : 16'd0);
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) state_d = DONE;
                end else begin
                    acc_d   = (mode_q == MODE_4B) ? {{8{mul_p[7]}}, mul_p} : {8'b0, mul_p};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_8B;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = acc_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corners plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  mode_i = 2'd0;
    logic [7:0]  a_i = 8'd0;
    logic [7:0]  b_i = 8'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] result_o;
    logic        err_o;
    logic        busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    mult_seq_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain signed arithmetic.
    function automatic logic [15:0] ref_result(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, p, l0, l1;
        logic [15:0] r;
        r = '0;
        case (m)
            2'd0: begin
                sa = $signed(a); sb = $signed(b); p = sa * sb; r = p[15:0];
            end
            2'd1: begin
                sa = $signed(a[3:0]); sb = $signed(b[3:0]); p = sa * sb; r = p[15:0];
            end
            2'd2: begin
                sa = $signed(a[1:0]); sb = $signed(b[1:0]); l0 = sa * sb;
                sa = $signed(a[3:2]); sb = $signed(b[3:2]); l1 = sa * sb;
                r = {8'b0, l1[3:0], l0[3:0]};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [1:0] m);
        case (m)
            2'd0:    return 5;
            2'd3:    return 1;
            default: return 2;
        endcase
    endfunction

    // One full transaction; accept edge counts as latency 1. Operands are
    // scrambled right after accept to show only latched values matter.
    task automatic do_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] res, output logic err);
        int guard;
        @(negedge clk_i);
        mode_i = m; a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        guard = 0;
        while (!in_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); mode_i = 2'($urandom);
        lat = 1;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
        err = err_o;
        @(negedge clk_i); out_ready_i = 1'b1;
        @(posedge clk_i); #1; out_ready_i = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        int lat; logic [15:0] res; logic err;
        logic [15:0] exp_res; logic exp_err; int exp_lat;
        do_op(m, a, b, lat, res, err);
        exp_res = ref_result(m, a, b);
        exp_err = (m == 2'd3);
        exp_lat = ref_latency(m);
        tests_run++;
        if (res !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result m=%0d a=%h b=%h: got %h expected %h", name, m, a, b, res, exp_res);
        end
        tests_run++;
        if (err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s err m=%0d a=%h b=%h: got %b expected %b", name, m, a, b, err, exp_err);
        end
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency m=%0d a=%h b=%h: got %0d expected %0d", name, m, a, b, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++;
        if ({in_ready_o, out_valid_o, result_o, err_o, busy_o} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h err=%b busy=%b expected 1 0 0000 0 0",
                     in_ready_o, out_valid_o, result_o, err_o, busy_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic test_8b_corners();
        logic [7:0] ta [10] = '{8'h80, 8'hFD, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F, 8'h55};
        logic [7:0] tb [10] = '{8'h80, 8'h07, 8'h7F, 8'h7F, 8'hFF, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hAA};
        for (int i = 0; i < 10; i++) check_op("mul8_corner", 2'd0, ta[i], tb[i]);
    endtask

    task automatic test_4b();
        check_op("mul4_min", 2'd1, 8'h08, 8'h07);
        for (int i = 0; i < 150; i++) check_op("mul4_rand", 2'd1, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_2x2();
        check_op("mul2x2_dir", 2'd2, 8'h09, 8'h0E);
        for (int i = 0; i < 150; i++) check_op("mul2x2_rand", 2'd2, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 5; i++) check_op("illegal_mode", 2'd3, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_random_8b();
        for (int i = 0; i < 1500; i++) check_op("mul8_rand", 2'd0, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 200; i++) check_op("mixed_rand", 2'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_backpressure();
        logic [7:0] a1, b1, a2, b2;
        logic [15:0] exp1, exp2;
        int lat;
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
        exp1 = ref_result(2'd0, a1, b1);
        exp2 = ref_result(2'd1, a2, b2);
        @(negedge clk_i);
        mode_i = 2'd0; a_i = a1; b_i = b1; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        mode_i = 2'd1; a_i = a2; b_i = b2;
        lat = 1;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if ({out_valid_o, in_ready_o, result_o, err_o} !== {1'b1, 1'b0, exp1, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b res=%h err=%b expected 1 0 %h 0",
                         c, out_valid_o, in_ready_o, result_o, err_o, exp1);
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i); out_ready_i = 1'b1;
        @(posedge clk_i); #1; out_ready_i = 1'b0;
        tests_run++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready_o, out_valid_o);
        end
        @(posedge clk_i); #1;
        tests_run++;
        if ({busy_o, in_ready_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bp_pending_accept: got busy=%b rdy=%b expected 1 0", busy_o, in_ready_o);
        end
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        tests_run++;
        if (result_o !== exp2 || lat !== 2) begin
            tests_failed++;
            $display("FAIL bp_pending_result: got %h lat %0d expected %h lat 2", result_o, lat, exp2);
        end
        @(negedge clk_i); out_ready_i = 1'b1;
        @(posedge clk_i); #1; out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int stale;
        @(negedge clk_i);
        mode_i = 2'd0; a_i = 8'h9C; b_i = 8'h6B; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({in_ready_o, out_valid_o, result_o, err_o, busy_o} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got rdy=%b vld=%b res=%h err=%b busy=%b expected 1 0 0000 0 0",
                     in_ready_o, out_valid_o, result_o, err_o, busy_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i); #1;
            if (out_valid_o || busy_o) stale++;
        end
        tests_run++;
        if (stale !== 0) begin
            tests_failed++;
            $display("FAIL midrst_no_stale: got %0d active cycles expected 0", stale);
        end
        check_op("midrst_next_op", 2'd0, 8'h9C, 8'h6B);
    endtask

    initial begin
        test_reset();
        test_8b_corners();
        test_4b();
        test_2x2();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        test_random_8b();
        test_mixed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
